// File: rtl/mod_exp_engine_if.sv
// Request/response bundle for the modular exponentiator.
// The master issues start with operands; the slave answers with busy/done/err/result.
interface mod_exp_engine_if #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exponent;
    logic [WIDTH-1:0]     p;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, base, exponent, p,
        input  busy, done, err, result
    );

    modport slave (
        input  start, base, exponent, p,
        output busy, done, err, result
    );
endinterface

// File: rtl/mod_exp_engine.sv
// Constant-time left-to-right square-and-multiply exponentiator.
// Every modular multiply is one product cycle plus a bit-serial restoring reduction.
module mod_exp_engine #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    mod_exp_engine_if.slave bus
);
    localparam int RED_CYCLES = 2 * WIDTH;
    localparam int CW = $clog2(RED_CYCLES);
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [3:0] {
        IDLE, LOAD, BRED, SQR, SRED, MUL, MRED, NEXT, DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]     base_q, p_q, acc, b;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [2*WIDTH-1:0]   prod, result_q;
    logic [WIDTH:0]       rem, rem_shift, rem_next;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic                 err_flag, done_q, err_q, busy;
    logic                 start_ok, red_last;
    logic [2*WIDTH-1:0]   acc_ext, b_ext;

    assign start_ok = bus.start && ((state == IDLE) || (state == DONE));
    assign red_last = (cnt == '0);
    assign acc_ext  = {{WIDTH{1'b0}}, acc};
    assign b_ext    = {{WIDTH{1'b0}}, b};

    // One restoring-division step: rem stays below p, so the shift fits in WIDTH+1 bits
    always_comb begin
        rem_shift = {rem[WIDTH-1:0], prod[cnt]};
        rem_next  = rem_shift;
        if (rem_shift >= {1'b0, p_q}) begin
            rem_next = rem_shift - {1'b0, p_q};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE) && (state != DONE);
        case (state)
            IDLE:    if (start_ok) state_next = LOAD;
            LOAD:    state_next = (p_q == '0) ? DONE : BRED;
            BRED:    if (red_last) state_next = SQR;
            SQR:     state_next = SRED;
            SRED:    if (red_last) state_next = MUL;
            MUL:     state_next = MRED;
            MRED:    if (red_last) state_next = NEXT;
            NEXT:    state_next = (idx == '0) ? DONE : SQR;
            DONE:    if (start_ok) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // done/err are registered from the DONE state, so they rise one edge after entering it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q   <= '0;
            p_q      <= '0;
            exp_q    <= '0;
            acc      <= '0;
            b        <= '0;
            prod     <= '0;
            rem      <= '0;
            cnt      <= '0;
            idx      <= '0;
            err_flag <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                base_q   <= bus.base;
                exp_q    <= bus.exponent;
                p_q      <= bus.p;
                result_q <= '0;
                done_q   <= 1'b0;
                err_q    <= 1'b0;
                err_flag <= 1'b0;
            end else if (state == DONE) begin
                done_q <= 1'b1;
                err_q  <= err_flag;
            end

            case (state)
                LOAD: begin
                    if (p_q == '0) begin
                        err_flag <= 1'b1;
                    end else begin
                        prod <= {{WIDTH{1'b0}}, base_q};
                        acc  <= WIDTH'(1);
                        idx  <= IW'(EXP_WIDTH - 1);
                        cnt  <= CW'(RED_CYCLES - 1);
                        rem  <= '0;
                    end
                end
                SQR, MUL: begin
                    prod <= (state == SQR) ? acc_ext * acc_ext : acc_ext * b_ext;
                    cnt  <= CW'(RED_CYCLES - 1);
                    rem  <= '0;
                end
                BRED, SRED, MRED: begin
                    rem <= rem_next;
                    cnt <= cnt - 1'b1;
                    if (red_last) begin
                        if (state == BRED) begin
                            b <= rem_next[WIDTH-1:0];
                        end else if (state == SRED || exp_q[idx]) begin
                            acc <= rem_next[WIDTH-1:0];
                        end
                    end
                end
                NEXT: begin
                    if (idx == '0) begin
                        result_q <= {{WIDTH{1'b0}}, acc};
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mod_exp_engine.sv
// Scoreboard bench for mod_exp_engine: driver queues expectations, monitor
// checks result, err, latency and busy duration on each rising done.
module tb_mod_exp_engine;
    localparam int W = 32;
    localparam int E = 32;
    localparam int L = 2 + 2*W + E*(2*(2*W+1)+1);

    typedef struct {
        string            name;
        logic [2*W-1:0]   result;
        logic             err;
        int               latency;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_exp_engine_if #(.WIDTH(W), .EXP_WIDTH(E)) bus();
    mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(E)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    int   busy_cnt  = 0;
    logic prev_done = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Monitor: pops one expectation per rising edge of done
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst && bus.busy) busy_cnt++;
        if (bus.done && !prev_done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0");
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_result"}, bus.result, e.result);
                checkOutput({e.name, "_err"}, 64'(bus.err), 64'(e.err));
                checkOutput({e.name, "_latency"}, 64'(cyc - start_cyc), 64'(e.latency));
                checkOutput({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.latency - 1));
                checkOutput({e.name, "_busy_with_done"}, 64'(bus.busy), 64'd0);
            end
        end
        prev_done = bus.done;
    end

    function automatic longint unsigned modexp(input longint unsigned b, input longint unsigned e,
                                               input longint unsigned m);
        longint unsigned r, bb;
        if (m == 0) return 0;
        r  = 1 % m;
        bb = b % m;
        for (int i = E-1; i >= 0; i--) begin
            r = (r * r) % m;
            if (e[i]) r = (r * bb) % m;
        end
        return r;
    endfunction

    task automatic applyStimulus(input string name, input logic [W-1:0] b, input logic [E-1:0] e,
                                 input logic [W-1:0] m, input logic [2*W-1:0] exp_res,
                                 input logic exp_err, input int exp_lat);
        exp_t x;
        @(negedge clk);
        bus.base     = b;
        bus.exponent = e;
        bus.p        = m;
        bus.start    = 1'b1;
        busy_cnt     = 0;
        start_cyc    = cyc + 1;
        x.name = name; x.result = exp_res; x.err = exp_err; x.latency = exp_lat;
        sb.push_back(x);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.base     = ~b;
        bus.exponent = ~e;
        bus.p        = m ^ 32'h5a5a_0001;
        checkOutput({name, "_done_cleared"}, 64'(bus.done), 64'd0);
        checkOutput({name, "_result_cleared"}, bus.result, 64'd0);
        checkOutput({name, "_err_cleared"}, 64'(bus.err), 64'd0);
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (sb.size() != 0 && n < L + 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout actual=%0d expected<=%0d", name, n, L + 50);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] rb, rm;
        logic [E-1:0] re;
        rst = 1'b0;
        bus.start = 1'b0; bus.base = '0; bus.exponent = '0; bus.p = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_err", 64'(bus.err), 64'd0);
        checkOutput("reset_result", bus.result, 64'd0);
        rst = 1'b1;

        applyStimulus("t1", 5, 3, 23, 10, 1'b0, L);            waitDone("t1");
        applyStimulus("t2a", 5, 6, 23, 8, 1'b0, L);            waitDone("t2a");
        checkOutput("t2a_hold_done", 64'(bus.done), 64'd1);
        checkOutput("t2a_hold_result", bus.result, 64'd8);
        applyStimulus("t2b", 5, 15, 23, 19, 1'b0, L);          waitDone("t2b");
        applyStimulus("t3a", 7, 0, 1000, 1, 1'b0, L);          waitDone("t3a");
        applyStimulus("t3b", 9, 13, 1, 0, 1'b0, L);            waitDone("t3b");
        applyStimulus("t4a", 5, 3, 0, 0, 1'b1, 2);             waitDone("t4a");
        applyStimulus("t4b", 5, 3, 23, 10, 1'b0, L);           waitDone("t4b");

        // Second start mid-run must be ignored
        applyStimulus("t5", 5, 6, 23, 8, 1'b0, L);
        repeat (98) @(negedge clk);
        bus.base = 3; bus.exponent = 7; bus.p = 11; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("t5_still_busy", 64'(bus.busy), 64'd1);
        waitDone("t5");

        // Asynchronous reset mid-run
        applyStimulus("t6a", 5, 3, 23, 10, 1'b0, L);
        repeat (1998) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("t6_rst_done", 64'(bus.done), 64'd0);
        checkOutput("t6_rst_err", 64'(bus.err), 64'd0);
        checkOutput("t6_rst_result", bus.result, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("t6b", 5, 15, 23, 19, 1'b0, L);          waitDone("t6b");

        for (int k = 0; k < 3; k++) begin
            rb = $urandom;
            re = $urandom;
            rm = $urandom | 32'h1;
            applyStimulus($sformatf("rand%0d", k), rb, re, rm,
                          64'(modexp(64'(rb), 64'(re), 64'(rm))), 1'b0, L);
            waitDone($sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
